mb_tx_lane_serializer: RTL

Parametrised mainband transmit serializer: accepts whole flits over a valid/ready handshake into a DEPTH-entry flit FIFO, then serializes them onto LANES data pins one bit per lane per clock, LSB first, with a framed valid pin. It is the single-clock, width/depth-generic successor to the fixed 16-lane mainband transmitter. It adds per-flit lane reversal, flush, a flit-done pulse and FIFO occupancy reporting. It sits between the flit source and the mainband pad drivers.

---
 rtl/mb_tx_pkg.sv | 19 +
 rtl/mb_tx_flit_fifo.sv | 64 ++++++
 rtl/mb_tx_lane_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mb_tx_pkg.sv
// Shared types and constants for the mainband transmit lane serializer.
// The byte-index helper is the single definition of the lane-to-byte mapping.
package mb_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int UI_PER_BYTE   = 8;
  localparam int VALID_HIGH_UI = 4;

  // Byte carried by a lane in a chunk; reversal mirrors lanes within the chunk.
  function automatic int byte_index(input int chunk, input int lane,
                                    input logic rev, input int lanes);
    return chunk * lanes + (rev ? (lanes - 1 - lane) : lane);
  endfunction

endpackage

// File: rtl/mb_tx_flit_fifo.sv
// DEPTH-entry flit FIFO with per-entry lane-reversal flag.
// The head entry is read combinationally, so a pushed flit is visible the next cycle.
module mb_tx_flit_fifo
  import mb_tx_pkg::*;
#(
  parameter int FLIT_BYTES = 64,
  parameter int DEPTH      = 4
) (
  input  logic                                     clk,
  input  logic                                     i_reset,
  input  logic                                     i_flush,
  input  logic                                     i_push,
  input  logic                                     i_pop,
  input  logic [FLIT_BYTES-1:0][UI_PER_BYTE-1:0]   i_wr_data,
  input  logic                                     i_wr_rev,
  output logic [FLIT_BYTES-1:0][UI_PER_BYTE-1:0]   o_head_data,
  output logic                                     o_head_rev,
  output logic [$clog2(DEPTH):0]                   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_BYTES-1:0][UI_PER_BYTE-1:0] r_data_mem [DEPTH];
  logic                                   r_rev_mem  [DEPTH];
  logic [PTR_W-1:0]                       r_wr_ptr;
  logic [PTR_W-1:0]                       r_rd_ptr;
  logic [CNT_W-1:0]                       r_count;
  logic                                   w_clear;

  assign w_clear = i_reset | i_flush;

  // NOTE: storage has no reset; validity is tracked by the count and pointers,
  // so clearing the array would only add reset fan-out to every flop.
  always_ff @(posedge clk) begin
    if (i_push && !w_clear) begin
      r_data_mem[r_wr_ptr] <= i_wr_data;
      r_rev_mem[r_wr_ptr]  <= i_wr_rev;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_data = r_data_mem[r_rd_ptr];
  assign o_head_rev  = r_rev_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/mb_tx_lane_serializer.sv
// Mainband transmit serializer: buffers whole flits and drives them LSB first,
// one bit per lane per clock, with a 4-high/4-low valid frame per byte.
module mb_tx_lane_serializer
  import mb_tx_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int FLIT_BYTES = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flit_valid_i,
  output logic                         flit_ready_o,
  input  logic [FLIT_BYTES-1:0][7:0]   data_i,
  input  logic                         lane_rev_i,
  input  logic                         flush_i,
  output logic [LANES-1:0]             data_pins_o,
  output logic                         valid_pin_o,
  output logic                         busy_o,
  output logic                         flit_done_o,
  output logic [$clog2(DEPTH):0]       fifo_count_o
);

  localparam int CHUNKS  = FLIT_BYTES / LANES;
  localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int UI_W    = $clog2(UI_PER_BYTE);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int BIDX_W  = $clog2(FLIT_BYTES);

  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
  localparam logic [UI_W-1:0]    LAST_UI    = UI_W'(UI_PER_BYTE - 1);
  localparam logic [UI_W-1:0]    VALID_END  = UI_W'(VALID_HIGH_UI);
  localparam logic [CNT_W-1:0]   FULL       = CNT_W'(DEPTH);

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic [UI_W-1:0]                 r_ui_cnt;
  logic [UI_W-1:0]                 w_ui_nxt;
  logic [CHUNK_W-1:0]              r_chunk;
  logic [CHUNK_W-1:0]              w_chunk_nxt;

  logic                            w_clear;
  logic                            w_push;
  logic                            w_last_ui;
  logic [CNT_W-1:0]                w_count;
  logic [FLIT_BYTES-1:0][7:0]      w_head_data;
  logic                            w_head_rev;
  logic [LANES-1:0]                w_lane_bit;

  assign w_clear      = reset | flush_i;
  assign flit_ready_o = !reset && !flush_i && (w_count != FULL);
  assign w_push       = flit_valid_i & flit_ready_o;
  assign w_last_ui    = (r_state == SEND) && (r_ui_cnt == LAST_UI) && (r_chunk == LAST_CHUNK);

  mb_tx_flit_fifo #(
    .FLIT_BYTES (FLIT_BYTES),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .i_reset     (reset),
    .i_flush     (flush_i),
    .i_push      (w_push),
    .i_pop       (w_last_ui),
    .i_wr_data   (data_i),
    .i_wr_rev    (lane_rev_i),
    .o_head_data (w_head_data),
    .o_head_rev  (w_head_rev),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state  <= IDLE;
      r_ui_cnt <= '0;
      r_chunk  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ui_cnt <= w_ui_nxt;
      r_chunk  <= w_chunk_nxt;
    end
  end

  // NOTE: every signal driven here is given a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ui_nxt    = r_ui_cnt;
    w_chunk_nxt = r_chunk;
    unique case (r_state)
      IDLE: begin
        w_ui_nxt    = '0;
        w_chunk_nxt = '0;
        if (w_count != '0) w_state_nxt = SEND;
      end
      SEND: begin
        w_ui_nxt = r_ui_cnt + UI_W'(1);
        if (w_last_ui) begin
          // Head pops this edge; keep sending if anything remains, including a same-edge push.
          w_chunk_nxt = '0;
          if ((w_count == CNT_W'(1)) && !w_push) w_state_nxt = IDLE;
        end else if (r_ui_cnt == LAST_UI) begin
          w_chunk_nxt = r_chunk + CHUNK_W'(1);
        end
      end
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BIDX_W-1:0] w_bidx;
    assign w_bidx        = BIDX_W'(byte_index(int'(r_chunk), l, w_head_rev, LANES));
    assign w_lane_bit[l] = w_head_data[w_bidx][r_ui_cnt];
  end

  assign busy_o       = (r_state == SEND);
  assign data_pins_o  = busy_o ? w_lane_bit : '0;
  assign valid_pin_o  = busy_o && (r_ui_cnt < VALID_END);
  assign flit_done_o  = w_last_ui && !w_clear;
  assign fifo_count_o = w_count;

endmodule
